// File: rtl/aes_key_sched_if.sv
// Round-key handshake bundle between the round controller and the AES-128 key schedule.
interface aes_key_sched_if;
    logic [127:0] key;
    logic         load;
    logic         next;
    logic [127:0] rnd_key;
    logic [3:0]   rnd;
    logic         key_valid;
    logic         last;

    modport master (
        output key, load, next,
        input  rnd_key, rnd, key_valid, last
    );

    modport slave (
        input  key, load, next,
        output rnd_key, rnd, key_valid, last
    );
endinterface

// File: rtl/aes_key_sched.sv
// On-the-fly AES-128 key expansion: one registered round key per advance, rounds 0..10.
// state  | meaning
// IDLE   | no valid round key; only load has an effect
// ACTIVE | key for round rnd_q is presented on rnd_key
module aes_key_sched #(
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            rst,
    aes_key_sched_if.slave  bus
);

    if (NR != 10) begin : g_bad_nr
        $error("aes_key_sched supports only NR = 10 (AES-128)");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         state, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [7:0]     rcon_q, rcon_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    t;
    logic [31:0]    w0_n, w1_n, w2_n, w3_n;

    assign {w0, w1, w2, w3} = key_q;

    // RotWord folded into the byte order fed to SubWord
    assign t    = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
    assign w0_n = w0 ^ t;
    assign w1_n = w1 ^ w0_n;
    assign w2_n = w2 ^ w1_n;
    assign w3_n = w3 ^ w2_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            key_q  <= '0;
            rnd_q  <= '0;
            rcon_q <= 8'h01;
        end else begin
            state  <= state_d;
            key_q  <= key_d;
            rnd_q  <= rnd_d;
            rcon_q <= rcon_d;
        end
    end

    always_comb begin
        state_d = state;
        key_d   = key_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        if (bus.load) begin
            state_d = ACTIVE;
            key_d   = bus.key;
            rnd_d   = '0;
            rcon_d  = 8'h01;
        end else if (bus.next && state == ACTIVE) begin
            if (rnd_q < LAST_RND) begin
                key_d  = {w0_n, w1_n, w2_n, w3_n};
                rnd_d  = rnd_q + 4'd1;
                rcon_d = xtime(rcon_q);
            end else begin
                // schedule exhausted: key, round and rcon stay put for inspection
                state_d = IDLE;
            end
        end
    end

    assign bus.rnd_key   = key_q;
    assign bus.rnd       = rnd_q;
    assign bus.key_valid = (state == ACTIVE);
    assign bus.last      = (state == ACTIVE) && (rnd_q == LAST_RND);

endmodule
